lab5_ifetch: RTL and testbench
==============================

// Module: lab5_ifetch
// PURPOSE
//  Instruction fetch stage sitting directly upstream of the 16-bit instruction RAM.
//  Owns the program counter and drives the RAM byte address. Captures the
//  combinational RAM read word into an instruction register for the decoder.
//  Handles stall, branch redirect, HALT detection and resume.
// PARAMETERS
//  ADDR_W     8        byte-address width of PC / IRAM_ADDR
//  INSTR_W    16       instruction word width
//  HALT_WORD  16'h0001 encoding that stops fetch
//  CNT_W      16       width of issued-instruction counter
// PORTS
//  CLK        in   1        rising-edge clock
//  RESET      in   1        synchronous, active-high reset
//  STALL      in   1        downstream not ready; hold IR/PC
//  BR_TAKEN   in   1        redirect request from execute stage
//  BR_TARGET  in   ADDR_W   redirect byte address; bit0 forced to 0
//  RESUME     in   1        leave HALTED (1-cycle pulse)
//  IRAM_ADDR  out  ADDR_W   byte address to IRAM, equals PC register (comb.)
//  IRAM_Q     in   INSTR_W  IRAM read word (combinational from IRAM_ADDR)
//  INSTR      out  INSTR_W  instruction register
//  INSTR_PC   out  ADDR_W   byte address INSTR was fetched from
//  INSTR_VALID out 1        INSTR holds a live instruction this cycle
//  HALTED     out  1        fetch stopped on HALT_WORD
//  FETCH_CNT  out  CNT_W    instructions issued since reset, saturating
// BEHAVIOUR
//  - Reset (RESET=1 at posedge): PC=0, INSTR=0, INSTR_PC=0, INSTR_VALID=0,
//    HALTED=0, FETCH_CNT=0, state=FETCH. Overrides every other input.
//  - Sole PC register drives IRAM_ADDR; bit0 always 0. IRAM read is
//    combinational, so fetch latency = 1 clock (addr -> INSTR).
//  - State FETCH; priority per edge: BR_TAKEN > STALL > HALT detect > normal:
//    * BR_TAKEN: PC<=BR_TARGET&~1; INSTR_VALID<=0 (squash); INSTR held.
//      Applies even when STALL=1.
//    * STALL (no BR_TAKEN): PC, INSTR, INSTR_PC, INSTR_VALID, FETCH_CNT held.
//    * IRAM_Q==HALT_WORD: INSTR_VALID<=0, HALTED<=1, PC<=PC+2, state->HALTED;
//      HALT word never issued, never counted.
//    * normal: INSTR<=IRAM_Q, INSTR_PC<=PC, INSTR_VALID<=1, PC<=PC+2,
//      FETCH_CNT<=FETCH_CNT+1 saturating at all-ones.
//  - State HALTED: INSTR_VALID=0, HALTED=1, PC held; BR_TAKEN and STALL
//    ignored. RESUME=1 -> HALTED<=0, state->FETCH; first fetch on next edge
//    from held PC (word after the HALT).
//  - RESUME in FETCH: no effect.
//  - PC arithmetic mod 2^ADDR_W: 8'hFE + 2 -> 8'h00, no flag.
//  - NOP word 16'h0000 issued and counted like any other instruction.
//  - RESET mid-run or in HALTED: all state returns to reset values same edge;
//    first fetch from address 0 on first edge with RESET=0.
// TESTING
//  1 Reset then run with IRAM program (word0=16'hF491, HALT at word8) ->
//    INSTR_VALID=1 on 8 edges with INSTR_PC 0x00..0x0E; 9th edge HALTED=1,
//    INSTR_VALID=0, IRAM_ADDR=0x12, FETCH_CNT=8.
//  2 From 1, pulse RESUME -> next edge INSTR=16'h4440, INSTR_PC=0x12,
//    HALTED=0, FETCH_CNT=9.
//  3 STALL high 3 cycles at PC=0x04 -> INSTR/INSTR_PC/FETCH_CNT frozen,
//    IRAM_ADDR stays 0x04; fetch resumes at 0x04 after release.
//  4 BR_TAKEN with BR_TARGET=0x15 while STALL=1 -> next edge PC=0x14,
//    INSTR_VALID=0; following edge INSTR_PC=0x14.
//  5 Branch to 0xFE over NOP region -> fetch 0xFE then IRAM_ADDR wraps to 0x00.
//  6 RESET asserted in HALTED and mid-fetch -> all outputs reset values, PC=0.

Source files
------------

// File: rtl/lab5_ifetch_if.sv
// Fetch-stage bus: execute/downstream controls, IRAM port and decoder-facing outputs.
interface lab5_ifetch_if #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned CNT_W   = 16
);
  logic               STALL;
  logic               BR_TAKEN;
  logic [ADDR_W-1:0]  BR_TARGET;
  logic               RESUME;
  logic [ADDR_W-1:0]  IRAM_ADDR;
  logic [INSTR_W-1:0] IRAM_Q;
  logic [INSTR_W-1:0] INSTR;
  logic [ADDR_W-1:0]  INSTR_PC;
  logic               INSTR_VALID;
  logic               HALTED;
  logic [CNT_W-1:0]   FETCH_CNT;

  // Fetch stage side
  modport master (
    input  STALL, BR_TAKEN, BR_TARGET, RESUME, IRAM_Q,
    output IRAM_ADDR, INSTR, INSTR_PC, INSTR_VALID, HALTED, FETCH_CNT
  );

  // Surrounding pipeline / IRAM side
  modport slave (
    output STALL, BR_TAKEN, BR_TARGET, RESUME, IRAM_Q,
    input  IRAM_ADDR, INSTR, INSTR_PC, INSTR_VALID, HALTED, FETCH_CNT
  );
endinterface

// File: rtl/lab5_ifetch.sv
// Instruction fetch stage: owns the PC, captures the IRAM word into the
// instruction register, and handles stall, branch redirect, HALT and resume.
module lab5_ifetch #(
  parameter int unsigned        ADDR_W    = 8,
  parameter int unsigned        INSTR_W   = 16,
  parameter int unsigned        CNT_W     = 16,
  parameter logic [INSTR_W-1:0] HALT_WORD = INSTR_W'(16'h0001)
) (
  input  logic          CLK,
  input  logic          RESET,
  lab5_ifetch_if.master bus
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HALT  = 1'b1
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic               halted;
  logic [CNT_W-1:0]   fetch_cnt;

  // IRAM is combinational, so the PC register is the read address directly
  assign bus.IRAM_ADDR   = pc;
  assign bus.INSTR       = instr;
  assign bus.INSTR_PC    = instr_pc;
  assign bus.INSTR_VALID = instr_valid;
  assign bus.HALTED      = halted;
  assign bus.FETCH_CNT   = fetch_cnt;

  // Fetch FSM: branch beats stall beats HALT detect beats normal issue
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= S_FETCH;
      pc          <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fetch_cnt   <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (bus.BR_TAKEN) begin
            // Redirect squashes the in-flight slot; INSTR keeps its old value
            pc          <= bus.BR_TARGET & ~ADDR_W'(1);
            instr_valid <= 1'b0;
          end else if (bus.STALL) begin
            pc          <= pc;
          end else if (bus.IRAM_Q == HALT_WORD) begin
            // HALT word is consumed but never issued or counted
            pc          <= pc + ADDR_W'(2);
            instr_valid <= 1'b0;
            halted      <= 1'b1;
            state       <= S_HALT;
          end else begin
            pc          <= pc + ADDR_W'(2);
            instr       <= bus.IRAM_Q;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            if (fetch_cnt != '1) begin
              fetch_cnt <= fetch_cnt + CNT_W'(1);
            end
          end
        end
        S_HALT: begin
          instr_valid <= 1'b0;
          if (bus.RESUME) begin
            halted <= 1'b0;
            state  <= S_FETCH;
          end
        end
        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lab5_ifetch.sv
// Self-checking bench for lab5_ifetch: directed scenarios then random traffic,
// every cycle compared against a behavioural fetch model.
module tb_lab5_ifetch;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned CNT_W   = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lab5_ifetch_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) bus();

  lab5_ifetch #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  // Instruction RAM model: 128 words, byte addressed, combinational read
  logic [15:0] mem [128];
  assign bus.IRAM_Q = mem[bus.IRAM_ADDR[7:1]];

  int vecs = 0;
  int errs = 0;

  // Reference model state
  int m_pc = 0, m_instr = 0, m_ipc = 0, m_valid = 0, m_halted = 0, m_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".iram_addr"},   32'(bus.IRAM_ADDR),   32'(m_pc));
    chk({tag, ".instr"},       32'(bus.INSTR),       32'(m_instr));
    chk({tag, ".instr_pc"},    32'(bus.INSTR_PC),    32'(m_ipc));
    chk({tag, ".instr_valid"}, 32'(bus.INSTR_VALID), 32'(m_valid));
    chk({tag, ".halted"},      32'(bus.HALTED),      32'(m_halted));
    chk({tag, ".fetch_cnt"},   32'(bus.FETCH_CNT),   32'(m_cnt));
  endtask

  // Apply one cycle of inputs, advance the model by the fetch rules, compare
  task automatic step(input string tag, input bit r, input bit s, input bit b,
                      input int tgt, input bit res);
    int q;
    rst           = r;
    bus.STALL     = s;
    bus.BR_TAKEN  = b;
    bus.BR_TARGET = 8'(tgt);
    bus.RESUME    = res;
    q = int'(mem[m_pc / 2]);
    @(posedge clk);
    if (r) begin
      m_pc = 0; m_instr = 0; m_ipc = 0; m_valid = 0; m_halted = 0; m_cnt = 0;
    end else if (m_halted != 0) begin
      m_valid = 0;
      if (res) m_halted = 0;
    end else if (b) begin
      m_pc    = tgt & 'hFE;
      m_valid = 0;
    end else if (s) begin
      // everything holds
    end else if (q == 1) begin
      m_valid  = 0;
      m_halted = 1;
      m_pc     = (m_pc + 2) % 256;
    end else begin
      m_instr = q;
      m_ipc   = m_pc;
      m_valid = 1;
      m_pc    = (m_pc + 2) % 256;
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
    end
    #1;
    check_all(tag);
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    if (w == 16'h0001) w = 16'h0002;
    return w;
  endfunction

  initial begin
    rst = 1'b1;
    bus.STALL = 1'b0; bus.BR_TAKEN = 1'b0; bus.BR_TARGET = '0; bus.RESUME = 1'b0;

    // Program: F491 at 0, HALT at word 8, 4440 after it, NOP region near the top
    for (int i = 0; i < 128; i++) mem[i] = rand_word();
    mem[0] = 16'hF491;
    mem[8] = 16'h0001;
    mem[9] = 16'h4440;
    for (int i = 120; i < 127; i++) mem[i] = 16'h0000;
    mem[127] = 16'hABCD;

    // Reset state
    step("reset0", 1, 0, 0, 0, 0);
    step("reset1", 1, 0, 0, 0, 0);
    chk("rst_addr", 32'(bus.IRAM_ADDR), 32'h0);
    chk("rst_valid", 32'(bus.INSTR_VALID), 32'h0);
    chk("rst_cnt", 32'(bus.FETCH_CNT), 32'h0);

    // Run to HALT
    for (int i = 0; i < 8; i++) begin
      step("run", 0, 0, 0, 0, 0);
      chk("run_ipc", 32'(bus.INSTR_PC), 32'(2 * i));
      chk("run_valid", 32'(bus.INSTR_VALID), 32'h1);
    end
    chk("first_instr_cnt", 32'(bus.FETCH_CNT), 32'd8);
    step("halt", 0, 0, 0, 0, 0);
    chk("halt_flag", 32'(bus.HALTED), 32'h1);
    chk("halt_valid", 32'(bus.INSTR_VALID), 32'h0);
    chk("halt_addr", 32'(bus.IRAM_ADDR), 32'h12);
    chk("halt_cnt", 32'(bus.FETCH_CNT), 32'd8);
    // Branch and stall ignored while halted; RESUME in a later cycle
    step("halt_ign", 0, 1, 1, 'h40, 0);
    chk("halt_ign_addr", 32'(bus.IRAM_ADDR), 32'h12);
    step("resume", 0, 0, 0, 0, 1);
    chk("resume_flag", 32'(bus.HALTED), 32'h0);
    step("post_resume", 0, 0, 0, 0, 0);
    chk("resume_instr", 32'(bus.INSTR), 32'h4440);
    chk("resume_ipc", 32'(bus.INSTR_PC), 32'h12);
    chk("resume_cnt", 32'(bus.FETCH_CNT), 32'd9);
    // RESUME while fetching does nothing
    step("resume_fetch", 0, 0, 0, 0, 1);

    // Stall at PC=0x04
    step("rst2", 1, 0, 0, 0, 0);
    step("pre_stall", 0, 0, 0, 0, 0);
    step("pre_stall", 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step("stall", 0, 1, 0, 0, 0);
      chk("stall_addr", 32'(bus.IRAM_ADDR), 32'h04);
      chk("stall_ipc", 32'(bus.INSTR_PC), 32'h02);
      chk("stall_cnt", 32'(bus.FETCH_CNT), 32'd2);
    end
    step("unstall", 0, 0, 0, 0, 0);
    chk("unstall_ipc", 32'(bus.INSTR_PC), 32'h04);

    // Branch while stalled to an odd target
    step("br_stall", 0, 1, 1, 'h15, 0);
    chk("br_addr", 32'(bus.IRAM_ADDR), 32'h14);
    chk("br_valid", 32'(bus.INSTR_VALID), 32'h0);
    step("post_br", 0, 0, 0, 0, 0);
    chk("post_br_ipc", 32'(bus.INSTR_PC), 32'h14);

    // Through the NOP region across the top of the address space
    step("br_top", 0, 0, 1, 'hF0, 0);
    for (int i = 0; i < 8; i++) step("nops", 0, 0, 0, 0, 0);
    chk("wrap_ipc", 32'(bus.INSTR_PC), 32'hFE);
    chk("wrap_instr", 32'(bus.INSTR), 32'hABCD);
    chk("wrap_addr", 32'(bus.IRAM_ADDR), 32'h00);
    step("wrapped", 0, 0, 0, 0, 0);
    chk("wrapped_instr", 32'(bus.INSTR), 32'hF491);

    // Reset mid-fetch, then reset from HALTED
    step("rst_mid", 1, 0, 0, 0, 0);
    chk("rst_mid_cnt", 32'(bus.FETCH_CNT), 32'h0);
    step("to_halt_br", 0, 0, 1, 'h10, 0);
    step("to_halt", 0, 0, 0, 0, 0);
    chk("to_halt_flag", 32'(bus.HALTED), 32'h1);
    step("rst_halt", 1, 0, 0, 0, 0);
    chk("rst_halt_flag", 32'(bus.HALTED), 32'h0);
    chk("rst_halt_addr", 32'(bus.IRAM_ADDR), 32'h0);
    step("after_rst", 0, 0, 0, 0, 0);
    chk("after_rst_instr", 32'(bus.INSTR), 32'hF491);

    // Random traffic over a random program with scattered HALTs
    for (int i = 0; i < 128; i++)
      mem[i] = ($urandom_range(15) == 0) ? 16'h0001 : rand_word();
    for (int i = 0; i < 500; i++) begin
      step("rand",
           $urandom_range(63) == 0,
           $urandom_range(3) == 0,
           $urandom_range(7) == 0,
           int'($urandom_range(255)),
           $urandom_range(2) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
